// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and default constants for the round-robin arbiter.
//   state_t      : arbiter FSM states (IDLE, GRANT, RELEASE)
//   N_DEF        : default number of requesters
//   MAX_HOLD_DEF : default maximum number of cycles one grant may be held
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Returns the first set request bit
// found when scanning ptr, ptr+1, ... modulo N.
//   req    : in  N bits, request vector
//   ptr    : in  $clog2(N) bits, index holding highest priority
//   any    : out 1 bit, at least one request is set
//   winner : out $clog2(N) bits, index of the selected requester (0 if none)
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = N_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] winner
);

    int idx;

    always_comb begin
        any    = |req;
        winner = '0;
        idx    = 0;
        // Scan from the farthest offset down to offset 0 so that the request
        // closest to ptr is the last assignment and therefore wins.
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a bounded hold time. A granted requester keeps the
// resource until it signals done, drops its request, or has held it for
// MAX_HOLD cycles. Every grant is followed by one RELEASE cycle with no owner,
// after which priority starts just past the previous owner.
//   clk      : in  clock, rising edge
//   reset    : in  synchronous active-high reset
//   req      : in  N bits, level-sensitive requests
//   done     : in  owner releases the resource (ignored when no grant held)
//   grant    : out N bits, one-hot grant or zero
//   grant_id : out $clog2(N) bits, owner index, valid while busy
//   busy     : out grant held
//   timeout  : out one-cycle pulse when a grant is revoked at the hold limit
// -----------------------------------------------------------------------------
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = N_DEF,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IW       = $clog2(N),
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          busy,
    output logic          timeout
);

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  grant_n;
    logic [IW-1:0] grant_id_n;
    logic          busy_n;
    logic          timeout_n;

    logic          pick_any;
    logic [IW-1:0] pick_win;
    logic          hit_limit;
    logic          owner_req;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] id);
        return (id == IW'(N - 1)) ? '0 : id + IW'(1);
    endfunction

    rr_pick #(
        .N (N)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_win)
    );

    // grant_id doubles as the owner register while in GRANT.
    assign owner_req = req[grant_id];
    assign hit_limit = (cnt == CW'(MAX_HOLD - 1));

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        cnt_n      = cnt;
        grant_n    = grant;
        grant_id_n = grant_id;
        busy_n     = busy;
        timeout_n  = 1'b0;

        case (state)
            IDLE, RELEASE: begin
                if (pick_any) begin
                    state_n    = GRANT;
                    grant_n    = {{(N-1){1'b0}}, 1'b1} << pick_win;
                    grant_id_n = pick_win;
                    busy_n     = 1'b1;
                    cnt_n      = '0;
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end
            end
            GRANT: begin
                if (done || !owner_req || hit_limit) begin
                    state_n   = RELEASE;
                    ptr_n     = next_ptr(grant_id);
                    grant_n   = '0;
                    busy_n    = 1'b0;
                    cnt_n     = '0;
                    // A voluntary release on the limit cycle is not a timeout.
                    timeout_n = hit_limit && !done && owner_req;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            grant    <= grant_n;
            grant_id <= grant_id_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
// Self-checking bench for rr_arbiter (N=4, MAX_HOLD=15). A behavioural model
// tracks the current owner, how long it has held the grant and where the next
// search starts; outputs are compared against it after every clock edge.
// Directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 15;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req   = '0;
    logic         done  = 1'b0;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    // Model state: owner index or -1, cycles held, next search start.
    int m_owner   = -1;
    int m_held    = 0;
    int m_start   = 0;
    bit m_timeout = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    function automatic int search(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        bit rel;
        if (reset) begin
            m_owner   = -1;
            m_held    = 0;
            m_start   = 0;
            m_timeout = 1'b0;
        end else if (m_owner >= 0) begin
            m_held    = m_held + 1;
            rel       = done || !req[m_owner] || (m_held == MH);
            m_timeout = rel && !done && req[m_owner];
            if (rel) begin
                m_start = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            // With no owner (idle or the gap after a grant) arbitration runs.
            m_timeout = 1'b0;
            m_owner   = search(req, m_start);
            m_held    = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] expg;
        expg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("model_grant", 32'(grant), 32'(expg));
        chk("model_busy", 32'(busy), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_timeout));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        if (m_owner >= 0) chk("model_grant_id", 32'(grant_id), 32'(m_owner));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    int held_cycles;

    initial begin
        // Reset state
        do_reset();
        step();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_id", 32'(grant_id), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);

        // First grant from ptr=0, then done hands over to requester 2
        req = 4'b0101;
        step();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_id", 32'(grant_id), 32'h0);
        chk("first_busy", 32'(busy), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done_release_grant", 32'(grant), 32'h0);
        chk("done_release_to", 32'(timeout), 32'h0);
        step();
        chk("handover_grant", 32'(grant), 32'h4);
        chk("handover_id", 32'(grant_id), 32'h2);

        // Sole requester held to the limit
        do_reset();
        req = 4'b0010;
        step();
        chk("hold_start", 32'(grant), 32'h2);
        held_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant == '0) break;
            held_cycles++;
        end
        chk("hold_length", 32'(held_cycles), 32'd15);
        chk("hold_timeout", 32'(timeout), 32'h1);
        step();
        chk("hold_regrant", 32'(grant), 32'h2);
        chk("hold_to_clear", 32'(timeout), 32'h0);

        // Full rotation with done pulsed on every grant
        do_reset();
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            chk("rot_busy", 32'(busy), 32'h1);
            chk("rot_id", 32'(grant_id), 32'(g % 4));
            done = 1'b1;
            step();
            done = 1'b0;
            chk("rot_gap", 32'(grant), 32'h0);
            step();
        end

        // Reset in the middle of a grant
        do_reset();
        req = 4'b0010;
        step();
        chk("mid_owner", 32'(grant_id), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_to", 32'(timeout), 32'h0);
        chk("mid_rst_id", 32'(grant_id), 32'h0);
        req = 4'b1010;
        step();
        chk("post_rst_id", 32'(grant_id), 32'h1);

        // done arriving on the limit cycle is a plain release
        do_reset();
        req = 4'b0001;
        step();
        for (int i = 0; i < 14; i++) step();
        chk("limit_still_held", 32'(grant), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("limit_done_grant", 32'(grant), 32'h0);
        chk("limit_done_to", 32'(timeout), 32'h0);

        // Randomised traffic, including occasional resets
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) req = N'($urandom);
            done  = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of cycles one grant may be held.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, N bits: request per requester, level-sensitive.
REQ-006 SHALL have port done, input, 1 bit: the current owner releases the shared resource.
REQ-007 SHALL have port grant, output, N bits: one-hot grant, or all zero when no grant is held.
REQ-008 SHALL have port grant_id, output, $clog2(N) bits: binary index of the owner, valid while busy=1.
REQ-009 SHALL have port busy, output, 1 bit: high while a grant is held.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked at MAX_HOLD.

Function
REQ-011 SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-012 SHALL keep a rotating priority pointer ptr (0..N-1); the winner is the first set req bit searching ptr, ptr+1, ... modulo N.
REQ-013 IDLE: any req bit set -> GRANT on the next edge with winner registered; else remain IDLE.
REQ-014 Latency: req sampled high in IDLE at edge k -> grant, grant_id and busy valid after edge k (registered outputs, no combinational path req->grant).
REQ-015 GRANT: hold counter starts at 0 on entry and increments each cycle in GRANT.
REQ-016 GRANT -> RELEASE when any of the following holds: done=1, req[owner]=0, or counter=MAX_HOLD-1.
REQ-017 timeout SHALL pulse for exactly one cycle, coincident with the first RELEASE cycle, only when the exit cause was the counter limit and neither done=1 nor req[owner]=0 held that cycle.
REQ-018 On entering RELEASE, ptr SHALL become (owner+1) mod N; grant=0 and busy=0 during RELEASE.
REQ-019 RELEASE: any req set -> GRANT with a new winner chosen using the updated ptr; else IDLE. There is therefore exactly one idle cycle between consecutive grants.
REQ-020 A requester whose grant was revoked SHALL NOT win again while any other req bit is set at the next arbitration (guaranteed by the ptr update).
REQ-021 grant SHALL never have more than one bit set; grant_id SHALL equal the index of the set bit; busy SHALL equal |grant.
REQ-022 req changes on non-owner bits during GRANT SHALL NOT affect the owner.
REQ-023 done while in IDLE or RELEASE SHALL be ignored.
REQ-024 The hold counter SHALL be $clog2(MAX_HOLD+1) bits wide and SHALL never wrap.

Reset
REQ-025 reset=1 at an edge -> state=IDLE, ptr=0, counter=0, grant=0, grant_id=0, busy=0, timeout=0 after that edge, regardless of the current state.
REQ-026 reset asserted mid-GRANT SHALL drop the grant after the same edge without a timeout pulse; the first arbitration after reset SHALL start from ptr=0.

Structure
REQ-027 Package arb_pkg SHALL hold the state enum typedef (IDLE, GRANT, RELEASE) and the default constants N_DEF=4 and MAX_HOLD_DEF=15.
REQ-028 The rotating priority search SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs any, winner index); rr_arbiter instantiates it once.
REQ-029 State, ptr, counter and all outputs SHALL be held in registers within rr_arbiter.

Verification
REQ-030 Reset then req=4'b0101 -> after 1 edge: grant=4'b0001, grant_id=0, busy=1.
REQ-031 From REQ-030, done=1 for one cycle with req held -> one RELEASE cycle (grant=0), then grant=4'b0100, grant_id=2.
REQ-032 req=4'b0010 held, done=0 -> grant held 15 cycles, then one RELEASE cycle with timeout=1, then grant=4'b0010 again (sole requester).
REQ-033 req=4'b1111 held, done pulsed every grant -> grant_id sequence 0,1,2,3,0, each grant separated by exactly one zero cycle.
REQ-034 Owner 1 granted, reset=1 for one cycle -> grant=0, busy=0, timeout=0 next cycle; with req=4'b1010 the next grant is id 1 (ptr=0).
REQ-035 done=1 on the same cycle the counter reaches 14 -> RELEASE with timeout=0.
